vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Generates 640x480@60 VGA raster timing: hsync, vsync, video_on, pixel coordinates and a linear pixel address.
- Sits directly upstream of the RGB frame-buffer reader.
  - Its video_on gates that reader's address counter and RGB outputs.
  - Its pixel_address is the index that reader must track.
- Runs from the system clock with an internal pixel-rate prescaler.

Parameters:
- CLOCK_DIVIDE, 2, system clocks per pixel (>=1); 50 MHz clock gives 25 MHz pixel rate.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).
- SYNC_ACTIVE_LEVEL, 0, logic level of hsync/vsync while asserted (0 = active-low).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pixel_tick  output  1  one-clock strobe, once per CLOCK_DIVIDE clocks; raster advances on it.
- hsync  output  1  horizontal sync, level per SYNC_ACTIVE_LEVEL.
- vsync  output  1  vertical sync, level per SYNC_ACTIVE_LEVEL.
- video_on  output  1  high while current pixel is in the visible region.
- pixel_x  output  10  current horizontal count, h_count.
- pixel_y  output  10  current vertical count, v_count.
- pixel_address  output  $clog2(H_ACTIVE*V_ACTIVE)  linear visible-pixel index; 19 bits at default.
- line_start  output  1  one-clock pulse at start of each line.
- frame_start  output  1  one-clock pulse at start of each frame.

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Prescaler:
  - Counts 0..CLOCK_DIVIDE-1 and wraps.
  - pixel_tick = (prescaler == CLOCK_DIVIDE-1).
  - CLOCK_DIVIDE=1: pixel_tick is constantly 1 outside reset.
- h_count:
  - Increments on pixel_tick.
  - At H_TOTAL-1 it wraps to 0 on pixel_tick and v_count advances.
- v_count:
  - Wraps to 0 after V_TOTAL-1.
  - Advances only when h_count wraps.
- Decode (combinational from counter registers, zero latency):
  - video_on = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
  - hsync asserted for h_count in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = [656,751].
  - vsync asserted for v_count in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] = [490,491].
  - pixel_x = h_count; pixel_y = v_count. Both are valid as coordinates only when video_on=1.
- line_start: high for the single clock where pixel_tick=1 and h_count==0.
- frame_start: high for the single clock where pixel_tick=1, h_count==0 and v_count==0.
- pixel_address:
  - Register; increments on pixel_tick while video_on=1.
  - Resets to 0 on the pixel_tick that wraps both counters at (H_TOTAL-1, V_TOTAL-1).
  - While video_on=1 it equals v_count*H_ACTIVE + h_count.
  - During blanking it holds the index of the next visible pixel.
  - After the last visible pixel it holds 307200 until the frame wrap.
- Reset:
  - Takes effect on the next clock edge, including mid-line or mid-frame.
  - Clears prescaler, h_count, v_count and pixel_address to 0.
  - While reset=1, forced outputs: pixel_tick=0, video_on=0, line_start=0, frame_start=0, hsync=vsync=!SYNC_ACTIVE_LEVEL.
- After reset release:
  - Raster restarts at (0,0), so video_on=1 from the first clock.
  - First pixel_tick occurs CLOCK_DIVIDE-1 clocks after release; frame_start pulses on it.
- Simultaneous h and v wrap: v_count wraps to 0 and h_count wraps to 0 on the same edge.

Optional Feature:
- Macro: VGA_TIMING_PIPE_ALIGN_EN.
- Defined:
  - hsync, vsync and video_on are each delayed by exactly one pixel period (re-registered on pixel_tick).
  - This aligns them with the frame buffer's one-cycle read latency.
  - pixel_x, pixel_y, pixel_address, line_start and frame_start stay undelayed.
  - The delay registers reset to the inactive values listed above.
- Undefined: all outputs are zero-latency decodes as in Behaviour.

Test Plan:
- CLOCK_DIVIDE=2, release reset -> pixel_tick at clocks 1,3,5...; frame_start one clock at clock 1; next frame_start exactly 840000 clocks later.
- Run one line -> video_on high for 1280 clocks, then low for 320; hsync=0 for exactly 192 clocks starting at h_count 656; line_start once per 1600 clocks.
- Run full frame -> vsync=0 exactly while v_count is 490 or 491 (2*800 ticks); video_on never high for v_count >= 480.
- Check pixel_address -> 0 at (0,0), 639 at (639,0), 640 at (0,1), 307199 at (639,479); holds 307200 until frame wrap, then 0.
- Assert reset for 1 clock mid-line at (300,200) -> next clock counters (0,0), pixel_address 0, syncs inactive, video_on 0; after release, timing restarts as in scenario 1.
- With VGA_TIMING_PIPE_ALIGN_EN defined -> video_on rises one tick after (0,0) and falls one tick after h_count 640; hsync starts at h_count 657; pixel_address unchanged versus the undelayed build.

Source files
------------

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - 640x480@60 VGA raster timing generator with pixel-rate prescaler
//
// Generates the raster counters for a frame, and decodes them into sync, blanking,
// coordinate and linear-address outputs for the RGB frame-buffer reader downstream.
//
// Optional feature macro: VGA_TIMING_PIPE_ALIGN_EN
//   When defined, hsync, vsync and video_on are re-registered on pixel_tick. This
//   delays them by one pixel period to match the frame buffer's read latency.
//   pixel_x, pixel_y, pixel_address, line_start and frame_start are not delayed.
//   When undefined, every output is a zero-latency decode of the counter registers.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   pixel_tick     out  one-clock strobe every CLOCK_DIVIDE clocks; raster advances on it
//   hsync          out  horizontal sync, asserted level = SYNC_ACTIVE_LEVEL
//   vsync          out  vertical sync, asserted level = SYNC_ACTIVE_LEVEL
//   video_on       out  current pixel lies in the visible region
//   pixel_x        out  horizontal count (10 bits)
//   pixel_y        out  vertical count (10 bits)
//   pixel_address  out  linear visible-pixel index, $clog2(H_ACTIVE*V_ACTIVE) bits
//   line_start     out  pulse on the tick at h_count == 0
//   frame_start    out  pulse on the tick at h_count == 0 and v_count == 0

module vga_timing_generator #(
  parameter int   CLOCK_DIVIDE      = 2,
  parameter int   H_ACTIVE          = 640,
  parameter int   H_FRONT           = 16,
  parameter int   H_SYNC            = 96,
  parameter int   H_BACK            = 48,
  parameter int   V_ACTIVE          = 480,
  parameter int   V_FRONT           = 10,
  parameter int   V_SYNC            = 2,
  parameter int   V_BACK            = 33,
  parameter logic SYNC_ACTIVE_LEVEL = 1'b0,
  localparam int  ADDR_W            = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              pixel_tick,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [9:0]        pixel_x,
  output logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] pixel_address,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // A one-bit prescaler is kept even for CLOCK_DIVIDE=1; it then never leaves 0.
  localparam int PS_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLOCK_DIVIDE - 1);
  localparam logic [9:0]      H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      HS_FIRST = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0]      HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]      V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      VS_FIRST = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]      VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [PS_W-1:0] prescaler;
  logic [9:0]      h_count;
  logic [9:0]      v_count;

  logic tick_raw;
  logic h_wrap;
  logic frame_wrap;
  logic video_raw;
  logic hsync_raw;
  logic vsync_raw;

  assign tick_raw   = (prescaler == PS_LAST);
  assign h_wrap     = (h_count == H_LAST);
  assign frame_wrap = h_wrap && (v_count == V_LAST);

  // Zero-latency decodes of the counter registers.
  assign video_raw = (h_count < H_VIS) && (v_count < V_VIS);
  assign hsync_raw = ((h_count >= HS_FIRST) && (h_count <= HS_LAST)) ?
                     SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
  assign vsync_raw = ((v_count >= VS_FIRST) && (v_count <= VS_LAST)) ?
                     SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;

  // Prescaler and raster counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      h_count   <= '0;
      v_count   <= '0;
    end else begin
      if (tick_raw) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PS_W'(1);
      end

      if (tick_raw) begin
        if (h_wrap) begin
          h_count <= '0;
          if (v_count == V_LAST) begin
            v_count <= '0;
          end else begin
            v_count <= v_count + 10'd1;
          end
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

  // Linear address: counts visible pixels already shown in this frame, so during
  // blanking it already points at the next visible pixel. The frame wrap check
  // comes first; the last raster position is never visible, so the two cases
  // cannot collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_address <= '0;
    end else if (tick_raw) begin
      if (frame_wrap) begin
        pixel_address <= '0;
      end else if (video_raw) begin
        pixel_address <= pixel_address + ADDR_W'(1);
      end
    end
  end

  assign pixel_tick  = tick_raw & ~reset;
  assign line_start  = pixel_tick && (h_count == 10'd0);
  assign frame_start = line_start && (v_count == 10'd0);
  assign pixel_x     = h_count;
  assign pixel_y     = v_count;

`ifdef VGA_TIMING_PIPE_ALIGN_EN
  logic hsync_q;
  logic vsync_q;
  logic video_q;

  // One pixel period of delay, matching the frame buffer read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_q <= ~SYNC_ACTIVE_LEVEL;
      vsync_q <= ~SYNC_ACTIVE_LEVEL;
      video_q <= 1'b0;
    end else if (tick_raw) begin
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
      video_q <= video_raw;
    end
  end

  assign hsync    = reset ? ~SYNC_ACTIVE_LEVEL : hsync_q;
  assign vsync    = reset ? ~SYNC_ACTIVE_LEVEL : vsync_q;
  assign video_on = video_q & ~reset;
`else
  assign hsync    = reset ? ~SYNC_ACTIVE_LEVEL : hsync_raw;
  assign vsync    = reset ? ~SYNC_ACTIVE_LEVEL : vsync_raw;
  assign video_on = video_raw & ~reset;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - self-checking bench for vga_timing_generator

`timescale 1ns/1ps

module tb_vga_timing_generator;

  typedef struct {
    int   d;
    int   ha;
    int   hf;
    int   hs;
    int   hb;
    int   va;
    int   vf;
    int   vs;
    int   vb;
    logic sl;
  } cfg_t;

  // Instance 0: default 640x480 timing. Instance 1: tiny raster, divide-by-3,
  // active-high syncs, so whole frames fit in a short run. Instance 2: divide-by-1.
  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    case (i)
      0:       c = '{d:2, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, sl:1'b0};
      1:       c = '{d:3, ha:16,  hf:2,  hs:4,  hb:3,  va:6,   vf:2,  vs:2, vb:3,  sl:1'b1};
      default: c = '{d:1, ha:10,  hf:3,  hs:2,  hb:1,  va:4,   vf:1,  vs:1, vb:2,  sl:1'b0};
    endcase
    return c;
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rst;

  logic       o_tick [3];
  logic       o_hs   [3];
  logic       o_vs   [3];
  logic       o_vid  [3];
  logic       o_ls   [3];
  logic       o_fs   [3];
  logic [9:0] o_x    [3];
  logic [9:0] o_y    [3];
  logic [31:0] o_addr [3];

  logic [18:0] addr_a;
  logic [6:0]  addr_b;
  logic [5:0]  addr_c;

  assign o_addr[0] = 32'(addr_a);
  assign o_addr[1] = 32'(addr_b);
  assign o_addr[2] = 32'(addr_c);

  vga_timing_generator dut_a (
    .clock(clock), .reset(rst[0]), .pixel_tick(o_tick[0]), .hsync(o_hs[0]), .vsync(o_vs[0]),
    .video_on(o_vid[0]), .pixel_x(o_x[0]), .pixel_y(o_y[0]), .pixel_address(addr_a),
    .line_start(o_ls[0]), .frame_start(o_fs[0])
  );

  vga_timing_generator #(
    .CLOCK_DIVIDE(3), .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE_LEVEL(1'b1)
  ) dut_b (
    .clock(clock), .reset(rst[1]), .pixel_tick(o_tick[1]), .hsync(o_hs[1]), .vsync(o_vs[1]),
    .video_on(o_vid[1]), .pixel_x(o_x[1]), .pixel_y(o_y[1]), .pixel_address(addr_b),
    .line_start(o_ls[1]), .frame_start(o_fs[1])
  );

  vga_timing_generator #(
    .CLOCK_DIVIDE(1), .H_ACTIVE(10), .H_FRONT(3), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .SYNC_ACTIVE_LEVEL(1'b0)
  ) dut_c (
    .clock(clock), .reset(rst[2]), .pixel_tick(o_tick[2]), .hsync(o_hs[2]), .vsync(o_vs[2]),
    .video_on(o_vid[2]), .pixel_x(o_x[2]), .pixel_y(o_y[2]), .pixel_address(addr_c),
    .line_start(o_ls[2]), .frame_start(o_fs[2])
  );

  int total = 0;
  int bad   = 0;
  int k     [3];
  bit valid [3];

  // k = clocks elapsed since the last clock edge that sampled reset high.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        k[i]     = 0;
        valid[i] = 1'b1;
      end else begin
        k[i] = k[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s inst=%0d k=%0d actual=%0d required=%0d", name, inst, k[inst], act, exp);
    end
  endtask

  // Sync/blanking decode of raster position q (pixel periods since frame origin).
  function automatic void decode(input cfg_t c, input int q,
                                 output logic vid, output logic hs, output logic vs);
    int ht;
    int vt;
    int h;
    int v;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    h   = q % ht;
    v   = (q / ht) % vt;
    vid = (h < c.ha) && (v < c.va);
    hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.sl : ~c.sl;
    vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.sl : ~c.sl;
  endfunction

  task automatic check_inst(input int i);
    cfg_t c;
    int   kk, p, ht, vt, h, v, ex_addr;
    logic tick, vid, hs, vs, ls, fs, r;
    c  = get_cfg(i);
    kk = k[i];
    r  = rst[i];
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    p  = kk / c.d;
    h  = p % ht;
    v  = (p / ht) % vt;
    tick = ((kk % c.d) == c.d - 1);
    ls   = tick && (h == 0);
    fs   = ls && (v == 0);
    // Visible pixels already passed in this frame.
    ex_addr = (v < c.va) ? (v * c.ha + ((h < c.ha) ? h : c.ha)) : (c.ha * c.va);
`ifdef VGA_TIMING_PIPE_ALIGN_EN
    if (p > 0) begin
      decode(c, p - 1, vid, hs, vs);
    end else begin
      vid = 1'b0;
      hs  = ~c.sl;
      vs  = ~c.sl;
    end
`else
    decode(c, p, vid, hs, vs);
`endif
    if (r) begin
      tick = 1'b0;
      vid  = 1'b0;
      ls   = 1'b0;
      fs   = 1'b0;
      hs   = ~c.sl;
      vs   = ~c.sl;
    end
    chk("pixel_tick",    i, 32'(o_tick[i]), 32'(tick));
    chk("hsync",         i, 32'(o_hs[i]),   32'(hs));
    chk("vsync",         i, 32'(o_vs[i]),   32'(vs));
    chk("video_on",      i, 32'(o_vid[i]),  32'(vid));
    chk("line_start",    i, 32'(o_ls[i]),   32'(ls));
    chk("frame_start",   i, 32'(o_fs[i]),   32'(fs));
    chk("pixel_x",       i, 32'(o_x[i]),    32'(h));
    chk("pixel_y",       i, 32'(o_y[i]),    32'(v));
    chk("pixel_address", i, o_addr[i],      32'(ex_addr));

    // Hand-computed points for the default timing (two clocks per pixel).
    if (i == 0 && !r) begin
      case (kk)
        0:    begin chk("lit_x0", i, 32'(o_x[i]), 32'd0); chk("lit_addr0", i, o_addr[i], 32'd0); end
        1:    begin chk("lit_tick1", i, 32'(o_tick[i]), 32'd1); chk("lit_fs1", i, 32'(o_fs[i]), 32'd1); end
        2:    chk("lit_tick2", i, 32'(o_tick[i]), 32'd0);
        1278: begin chk("lit_x639", i, 32'(o_x[i]), 32'd639); chk("lit_addr639", i, o_addr[i], 32'd639); end
        1280: chk("lit_addr_hold640", i, o_addr[i], 32'd640);
        1600: begin chk("lit_y1", i, 32'(o_y[i]), 32'd1); chk("lit_addr_line1", i, o_addr[i], 32'd640); end
        1601: begin chk("lit_ls", i, 32'(o_ls[i]), 32'd1); chk("lit_fs_not", i, 32'(o_fs[i]), 32'd0); end
`ifdef VGA_TIMING_PIPE_ALIGN_EN
        1313: chk("lit_hs_656_pipe", i, 32'(o_hs[i]), 32'd1);
        1314: chk("lit_hs_657_pipe", i, 32'(o_hs[i]), 32'd0);
`else
        1311: chk("lit_hs_655", i, 32'(o_hs[i]), 32'd1);
        1312: chk("lit_hs_656", i, 32'(o_hs[i]), 32'd0);
        1502: chk("lit_hs_751", i, 32'(o_hs[i]), 32'd0);
        1504: chk("lit_hs_752", i, 32'(o_hs[i]), 32'd1);
`endif
        default: ;
      endcase
    end

    // Hand-computed points for the small raster (25 x 13, three clocks per pixel).
    if (i == 1 && !r) begin
      case (kk)
        2:   chk("lit_b_fs_first", i, 32'(o_fs[i]), 32'd1);
        420: chk("lit_b_addr_last", i, o_addr[i], 32'd95);
        423: chk("lit_b_addr_full", i, o_addr[i], 32'd96);
        525: chk("lit_b_addr_hold", i, o_addr[i], 32'd96);
        974: chk("lit_b_addr_end", i, o_addr[i], 32'd96);
        975: chk("lit_b_addr_wrap", i, o_addr[i], 32'd0);
        977: chk("lit_b_fs_second", i, 32'(o_fs[i]), 32'd1);
`ifndef VGA_TIMING_PIPE_ALIGN_EN
        599: chk("lit_b_vs_v7", i, 32'(o_vs[i]), 32'd0);
        600: chk("lit_b_vs_v8", i, 32'(o_vs[i]), 32'd1);
`endif
        default: ;
      endcase
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) check_inst(i);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      k[i]     = 0;
      valid[i] = 1'b0;
    end
    rst = 3'b111;
    repeat (3) @(posedge clock);
    #1 rst = 3'b000;
    repeat (4000) @(posedge clock);
    // Random reset pulses landing mid-line / mid-frame on random instances.
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(50, 1500)) @(posedge clock);
      #1 rst = 3'($urandom_range(1, 7));
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #1 rst = 3'b000;
    end
    repeat (2000) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
